// File: rtl/adma_dm_axi_r_route.sv
// adma_dm_axi_r_route: routes AXI R beats by RID to per-channel streams using an outstanding-AR table
module adma_dm_axi_r_route #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_RESP_W     = 2,
  parameter int ATX_SRC_DATA_W = 256,
  parameter int ATX_NUM_OSTD   = 4,
  parameter int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DMA_CHN_NUM_W-1:0]    atx_chn_id,
  input  logic [MST_ID_W-1:0]         atx_arid,
  input  logic [ATX_LEN_W-1:0]        atx_arlen,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  output logic [ATX_SRC_DATA_W-1:0]   chn_rdata     [0:DMA_CHN_NUM-1],
  output logic                        chn_rlast     [0:DMA_CHN_NUM-1],
  output logic                        chn_rdata_vld [0:DMA_CHN_NUM-1],
  input  logic                        chn_rdata_rdy [0:DMA_CHN_NUM-1],
  output logic [1:0]                  chn_err       [0:DMA_CHN_NUM-1],
  input  logic                        chn_err_clr   [0:DMA_CHN_NUM-1],
  output logic                        rid_err,
  output logic [$clog2(ATX_NUM_OSTD+1)-1:0] ostd_cnt,
  input  logic [MST_ID_W-1:0]         m_rid_i,
  input  logic [ATX_SRC_DATA_W-1:0]   m_rdata_i,
  input  logic [ATX_RESP_W-1:0]       m_rresp_i,
  input  logic                        m_rlast_i,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o
);
  localparam int IW = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int CW = $clog2(ATX_NUM_OSTD + 1);
  logic [ATX_NUM_OSTD-1:0] ent_vld;
  logic [MST_ID_W-1:0] ent_id [ATX_NUM_OSTD];
  logic [DMA_CHN_NUM_W-1:0] ent_chn [ATX_NUM_OSTD];
  logic [ATX_LEN_W-1:0] ent_rem [ATX_NUM_OSTD];
  logic [IW-1:0] free_idx, hit_idx;
  logic [DMA_CHN_NUM_W-1:0] hit_chn;
  logic free_any, dup, hit, alloc, hs, fr, rem_zero, len_err, resp_err;
  always_comb begin
    free_any = 1'b0;
    dup = 1'b0;
    hit = 1'b0;
    free_idx = '0;
    hit_idx = '0;
    for (int i = ATX_NUM_OSTD - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_vld[i] && ent_id[i] == atx_arid) dup = 1'b1;
      if (ent_vld[i] && ent_id[i] == m_rid_i) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end
  assign hit_chn = ent_chn[hit_idx];
  assign rem_zero = ent_rem[hit_idx] == '0;
  assign atx_rdy = !rst && free_any && !dup;
  assign alloc = atx_vld && atx_rdy;
  // misses are always accepted so an unknown RID can never stall the bus
  always_comb begin
    m_rready_o = !rst && !hit;
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      chn_rdata[c] = m_rdata_i;
      chn_rlast[c] = m_rlast_i;
      chn_rdata_vld[c] = !rst && hit && m_rvalid_i && hit_chn == DMA_CHN_NUM_W'(c);
      if (!rst && hit && hit_chn == DMA_CHN_NUM_W'(c)) m_rready_o = chn_rdata_rdy[c];
    end
  end
  assign hs = hit && m_rvalid_i && m_rready_o;
  assign fr = hs && m_rlast_i;
  assign len_err = hs && (m_rlast_i != rem_zero);
  assign resp_err = hs && (m_rresp_i >= ATX_RESP_W'(2));
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      rid_err <= 1'b0;
      ostd_cnt <= '0;
      for (int c = 0; c < DMA_CHN_NUM; c++) chn_err[c] <= 2'b00;
    end else begin
      if (alloc) begin
        ent_vld[free_idx] <= 1'b1;
        ent_id[free_idx] <= atx_arid;
        ent_chn[free_idx] <= atx_chn_id;
        ent_rem[free_idx] <= atx_arlen;
      end
      if (hs && !m_rlast_i && !rem_zero) ent_rem[hit_idx] <= ent_rem[hit_idx] - 1'b1;
      if (fr) ent_vld[hit_idx] <= 1'b0;
      if (m_rvalid_i && !hit) rid_err <= 1'b1;
      ostd_cnt <= ostd_cnt + CW'(alloc) - CW'(fr);
      for (int c = 0; c < DMA_CHN_NUM; c++)
        chn_err[c] <= (chn_err_clr[c] ? 2'b00 : chn_err[c]) |
                      ((hs && hit_chn == DMA_CHN_NUM_W'(c)) ? {len_err, resp_err} : 2'b00);
    end
  end
endmodule

// File: tb/tb_adma_dm_axi_r_route.sv
// tb_adma_dm_axi_r_route: directed self-checking bench for the R-channel router
module tb_adma_dm_axi_r_route;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] atx_chn_id;
  logic [4:0] atx_arid;
  logic [7:0] atx_arlen;
  logic atx_vld, atx_rdy;
  logic [255:0] chn_rdata [0:3];
  logic chn_rlast [0:3];
  logic chn_rdata_vld [0:3];
  logic chn_rdata_rdy [0:3];
  logic [1:0] chn_err [0:3];
  logic chn_err_clr [0:3];
  logic rid_err;
  logic [2:0] ostd_cnt;
  logic [4:0] m_rid_i;
  logic [255:0] m_rdata_i;
  logic [1:0] m_rresp_i;
  logic m_rlast_i, m_rvalid_i, m_rready_o;
  int n_tests = 0;
  int n_fail = 0;
  adma_dm_axi_r_route dut (
    .clk(clk), .rst(rst),
    .atx_chn_id(atx_chn_id), .atx_arid(atx_arid), .atx_arlen(atx_arlen),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .chn_rdata(chn_rdata), .chn_rlast(chn_rlast), .chn_rdata_vld(chn_rdata_vld),
    .chn_rdata_rdy(chn_rdata_rdy), .chn_err(chn_err), .chn_err_clr(chn_err_clr),
    .rid_err(rid_err), .ostd_cnt(ostd_cnt),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] vv();
    for (int c = 0; c < 4; c++) vv[c] = chn_rdata_vld[c];
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] c, input logic [4:0] id, input logic [7:0] len);
    atx_chn_id = c;
    atx_arid = id;
    atx_arlen = len;
    atx_vld = 1'b1;
    #1 chk("atx_rdy_issue", 64'(atx_rdy), 64'd1);
    step();
    atx_vld = 1'b0;
  endtask
  task automatic beat(input logic [4:0] id, input logic [63:0] d, input logic [1:0] resp,
                      input logic last, input logic [3:0] ev, input logic er);
    m_rid_i = id;
    m_rdata_i = {4{d}};
    m_rresp_i = resp;
    m_rlast_i = last;
    m_rvalid_i = 1'b1;
    #1;
    chk("r_vld", 64'(vv()), 64'(ev));
    chk("rready", 64'(m_rready_o), 64'(er));
    chk("rdata", chn_rdata[2][63:0], d);
    chk("rlast", 64'(chn_rlast[3]), 64'(last));
    step();
    m_rvalid_i = 1'b0;
    m_rlast_i = 1'b0;
  endtask
  initial begin
    atx_chn_id = '0; atx_arid = '0; atx_arlen = '0; atx_vld = 1'b0;
    m_rid_i = '0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0; m_rvalid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chn_rdata_rdy[c] = 1'b1;
      chn_err_clr[c] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_atx_rdy", 64'(atx_rdy), 64'd0);
    chk("rst_rready", 64'(m_rready_o), 64'd0);
    chk("rst_ostd", 64'(ostd_cnt), 64'd0);
    chk("rst_vld", 64'(vv()), 64'd0);
    chk("rst_rid_err", 64'(rid_err), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_atx_rdy", 64'(atx_rdy), 64'd1);
    // single burst on ch1
    issue(2'd1, 5'd3, 8'd3);
    chk("b1_ostd", 64'(ostd_cnt), 64'd1);
    for (int k = 0; k < 4; k++) beat(5'd3, 64'(100 + k), 2'b00, k == 3, 4'b0010, 1'b1);
    chk("b1_ostd_end", 64'(ostd_cnt), 64'd0);
    chk("b1_err", 64'(chn_err[1]), 64'd0);
    // interleaved ch0/ch2
    issue(2'd0, 5'd1, 8'd1);
    issue(2'd2, 5'd2, 8'd1);
    chk("il_ostd", 64'(ostd_cnt), 64'd2);
    beat(5'd2, 64'h20, 2'b00, 1'b0, 4'b0100, 1'b1);
    beat(5'd1, 64'h10, 2'b00, 1'b0, 4'b0001, 1'b1);
    beat(5'd2, 64'h21, 2'b00, 1'b1, 4'b0100, 1'b1);
    beat(5'd1, 64'h11, 2'b00, 1'b1, 4'b0001, 1'b1);
    chk("il_ostd_end", 64'(ostd_cnt), 64'd0);
    // duplicate ID blocks until freed
    issue(2'd0, 5'd5, 8'd0);
    atx_arid = 5'd5;
    atx_vld = 1'b1;
    #1 chk("dup_rdy0", 64'(atx_rdy), 64'd0);
    step();
    chk("dup_rdy1", 64'(atx_rdy), 64'd0);
    chk("dup_ostd", 64'(ostd_cnt), 64'd1);
    beat(5'd5, 64'h50, 2'b00, 1'b1, 4'b0001, 1'b1);
    chk("dup_rdy_after", 64'(atx_rdy), 64'd1);
    chk("dup_ostd_free", 64'(ostd_cnt), 64'd0);
    step();
    atx_vld = 1'b0;
    chk("dup_ostd_realloc", 64'(ostd_cnt), 64'd1);
    beat(5'd5, 64'h51, 2'b00, 1'b1, 4'b0001, 1'b1);
    chk("dup_ostd_end", 64'(ostd_cnt), 64'd0);
    // early last on ch3, clear, set-vs-clear
    issue(2'd3, 5'd4, 8'd3);
    beat(5'd4, 64'h40, 2'b00, 1'b0, 4'b1000, 1'b1);
    beat(5'd4, 64'h41, 2'b00, 1'b1, 4'b1000, 1'b1);
    chk("early_err", 64'(chn_err[3]), 64'd2);
    chk("early_ostd", 64'(ostd_cnt), 64'd0);
    chn_err_clr[3] = 1'b1;
    step();
    chn_err_clr[3] = 1'b0;
    chk("clr_err", 64'(chn_err[3]), 64'd0);
    issue(2'd3, 5'd4, 8'd1);
    chn_err_clr[3] = 1'b1;
    beat(5'd4, 64'h42, 2'b00, 1'b1, 4'b1000, 1'b1);
    chn_err_clr[3] = 1'b0;
    chk("setclr_err", 64'(chn_err[3]), 64'd2);
    // overrun on ch2
    issue(2'd2, 5'd6, 8'd0);
    beat(5'd6, 64'h60, 2'b00, 1'b0, 4'b0100, 1'b1);
    chk("ovr_err", 64'(chn_err[2]), 64'd2);
    chk("ovr_ostd", 64'(ostd_cnt), 64'd1);
    beat(5'd6, 64'h61, 2'b00, 1'b0, 4'b0100, 1'b1);
    beat(5'd6, 64'h62, 2'b00, 1'b1, 4'b0100, 1'b1);
    chk("ovr_ostd_end", 64'(ostd_cnt), 64'd0);
    // response error and unknown RID
    issue(2'd0, 5'd8, 8'd0);
    beat(5'd8, 64'h80, 2'b11, 1'b1, 4'b0001, 1'b1);
    chk("resp_err", 64'(chn_err[0]), 64'd1);
    chk("rid_err_pre", 64'(rid_err), 64'd0);
    beat(5'd7, 64'h70, 2'b00, 1'b1, 4'b0000, 1'b1);
    chk("rid_err", 64'(rid_err), 64'd1);
    // backpressure on ch1 holds the beat and rem
    issue(2'd1, 5'd9, 8'd3);
    beat(5'd9, 64'h90, 2'b00, 1'b0, 4'b0010, 1'b1);
    chn_rdata_rdy[1] = 1'b0;
    m_rid_i = 5'd9;
    m_rdata_i = {4{64'h91}};
    m_rresp_i = 2'b00;
    m_rlast_i = 1'b0;
    m_rvalid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_rready", 64'(m_rready_o), 64'd0);
      chk("stall_vld", 64'(vv()), 64'b0010);
      chk("stall_data", chn_rdata[1][63:0], 64'h91);
      step();
    end
    chn_rdata_rdy[1] = 1'b1;
    #1 chk("stall_release", 64'(m_rready_o), 64'd1);
    step();
    m_rvalid_i = 1'b0;
    beat(5'd9, 64'h92, 2'b00, 1'b0, 4'b0010, 1'b1);
    beat(5'd9, 64'h93, 2'b00, 1'b1, 4'b0010, 1'b1);
    chk("stall_err", 64'(chn_err[1]), 64'd0);
    chk("stall_ostd", 64'(ostd_cnt), 64'd0);
    // table full, then reset mid-burst
    for (int k = 0; k < 4; k++) issue(2'(k), 5'(10 + k), 8'd1);
    chk("full_ostd", 64'(ostd_cnt), 64'd4);
    atx_arid = 5'd14;
    atx_vld = 1'b1;
    #1 chk("full_rdy", 64'(atx_rdy), 64'd0);
    atx_vld = 1'b0;
    step();
    beat(5'd10, 64'ha0, 2'b00, 1'b0, 4'b0001, 1'b1);
    rst = 1'b1;
    m_rid_i = 5'd11;
    m_rvalid_i = 1'b1;
    #1;
    chk("mrst_vld", 64'(vv()), 64'd0);
    chk("mrst_rready", 64'(m_rready_o), 64'd0);
    chk("mrst_atx_rdy", 64'(atx_rdy), 64'd0);
    step();
    m_rvalid_i = 1'b0;
    chk("mrst_ostd", 64'(ostd_cnt), 64'd0);
    chk("mrst_err0", 64'(chn_err[0]), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rid_err", 64'(rid_err), 64'd0);
    chk("post_atx_rdy", 64'(atx_rdy), 64'd1);
    beat(5'd11, 64'hb0, 2'b00, 1'b1, 4'b0000, 1'b1);
    chk("post_miss", 64'(rid_err), 64'd1);
    chk("post_ostd", 64'(ostd_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adma_dm_axi_r_route.md
Name: adma_dm_axi_r_route

Overview:
Multi-channel AXI read-data router for the ADMA datamover; successor to the single-stream R-channel block. It tracks up to ATX_NUM_OSTD outstanding AR transactions in an ID table and steers each R beat by RID to a dedicated per-channel stream, so interleaved responses from different channels proceed without a reorder buffer. It also checks RLAST against the issued ARLEN and keeps per-channel sticky error status with software clear. It sits between the AR issuer and the per-channel write-side datamovers.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels / output streams
MST_ID_W, 5, AXI ID width
ATX_LEN_W, 8, ARLEN width
ATX_RESP_W, 2, RRESP width
ATX_SRC_DATA_W, 256, RDATA width
ATX_NUM_OSTD, 4, outstanding-table entries (>=1)
DMA_CHN_NUM_W, (DMA_CHN_NUM>1)?$clog2(DMA_CHN_NUM):1, derived, do not override

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
atx_chn_id  in  DMA_CHN_NUM_W  channel owning the issued AR
atx_arid  in  MST_ID_W  ARID of issued AR
atx_arlen  in  ATX_LEN_W  ARLEN (beats-1)
atx_vld  in  1  AR info valid
atx_rdy  out  1  table can accept AR info
chn_rdata  out  ATX_SRC_DATA_W [0:DMA_CHN_NUM-1]  per-channel data
chn_rlast  out  1 [0:DMA_CHN_NUM-1]  per-channel last, forwarded RLAST
chn_rdata_vld  out  1 [0:DMA_CHN_NUM-1]  per-channel valid
chn_rdata_rdy  in  1 [0:DMA_CHN_NUM-1]  per-channel ready
chn_err  out  2 [0:DMA_CHN_NUM-1]  sticky {len_err, resp_err}
chn_err_clr  in  1 [0:DMA_CHN_NUM-1]  clears chn_err of that channel
rid_err  out  1  sticky: beat with unknown RID received (cleared by rst only)
ostd_cnt  out  $clog2(ATX_NUM_OSTD+1)  valid table entries
m_rid_i, m_rdata_i, m_rresp_i, m_rlast_i, m_rvalid_i  in  AXI R channel
m_rready_o  out  1  AXI RREADY

Behaviour:
- Table entry: {vld, id, chn, rem[ATX_LEN_W]}. Reset clears all vld, chn_err, rid_err; ostd_cnt=0; atx_rdy=0, m_rready_o=0, all chn_rdata_vld=0 while rst high.
- atx_rdy = any free entry AND no valid entry with id==atx_arid; both evaluated on the registered (pre-cycle) table. On atx_vld&atx_rdy, the lowest free index gets {1, arid, chn_id, arlen}. Only one entry per ID, so same-ID ordering needs no age tracking.
- R lookup is combinational: hit = valid entry with id==m_rid_i. Data path is zero-latency.
- Hit: chn_rdata_vld[chn]=m_rvalid_i, chn_rdata/chn_rlast driven from R, m_rready_o=chn_rdata_rdy[chn]. Non-target channels have vld=0. chn_rdata is the same bus broadcast to all channels.
- Miss with m_rvalid_i: m_rready_o=1, beat dropped, rid_err set.
- On hit handshake:
  - rem!=0 and !rlast: rem-=1.
  - rem==0 and rlast: entry freed.
  - rem!=0 and rlast (early last): len_err set, entry freed.
  - rem==0 and !rlast (overrun): len_err set, rem held at 0, entry kept until RLAST.
- resp_err is set on a hit handshake with RRESP==2'b10 or 2'b11.
- chn_err set beats chn_err_clr in the same cycle.
- An entry freed in cycle N is allocatable in cycle N+1 (atx_rdy uses the registered table), including reuse of the same ID.
- ostd_cnt += alloc, -= free; simultaneous alloc and free leaves it unchanged.
- Reset asserted mid-burst discards all entries. Beats arriving after reset are treated as misses.

Test Plan:
- Issue ch1 {id=3, len=3}; 4 beats id=3, last on beat 4 -> 4 beats appear only on chn_rdata_vld[1], chn_rlast[1] on beat 4, ostd_cnt 1->0, chn_err[1]=0.
- Issue ch0 id=1 len=1 and ch2 id=2 len=1; interleave R id=2,1,2,1 -> each channel receives its own 2 beats in order; both entries freed.
- Issue id=5 twice back-to-back -> second atx_rdy=0 until the cycle after id=5's RLAST handshake; ostd_cnt never exceeds 1.
- ch3 len=3 with RLAST on beat 2 -> chn_err[3]=2'b10, entry freed; chn_err_clr[3] pulse -> 2'b00. Set and clear in the same cycle -> stays set.
- Beat with RRESP=2'b11 on ch0 -> chn_err[0]=2'b01. R beat id=7 with no entry -> m_rready_o=1, no channel valid, rid_err=1.
- Hold chn_rdata_rdy[1]=0 for 5 cycles mid-burst -> m_rready_o=0, rem unchanged, data held; fill 4 entries -> atx_rdy=0; assert rst mid-burst -> ostd_cnt=0 and outputs deasserted next cycle.
